pwl_filter_reset_sequencer: RTL and testbench

//  Clocked controller for the PWL linear filter with reset path. It owns the filter's reset, pole/zero and mode inputs.
//  - Accepts new filter configs over a req/ack handshake and validates them.
//  - Each accepted config: forces the filter into its reset path, applies the new poles/zero while in reset, releases, waits a settle window, then reports ready.
//  - Sits between the digital config/calibration logic and the analog-behavioural filter instance.

---
 rtl/pwl_filter_seq_pkg.sv | 14 +
 rtl/pwl_filter_seq_cfg_check.sv | 23 ++
 rtl/pwl_filter_reset_sequencer.sv | 143 ++++++++++++++
 tb/tb_pwl_filter_reset_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwl_filter_seq_pkg.sv
// Shared types and constants for the PWL filter reset sequencer.
package pwl_filter_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_SETTLE
    } seq_state_t;

    localparam int FT_ONE_POLE      = 0;
    localparam int FT_TWO_POLE      = 1;
    localparam int FT_TWO_POLE_ZERO = 2;

endpackage

// File: rtl/pwl_filter_seq_cfg_check.sv
// Combinational validity check of a requested filter config.
module pwl_filter_seq_cfg_check
    import pwl_filter_seq_pkg::*;
#(
    parameter int FILTER = 0
) (
    input  real  fp1,
    input  real  fp2,
    input  real  fz1,
    output logic ok
);

    always_comb begin
        ok = 1'b1;
        if (fp1 <= 0.0)
            ok = 1'b0;
        if (FILTER >= FT_TWO_POLE && fp2 <= 0.0)
            ok = 1'b0;
        if (FILTER == FT_TWO_POLE_ZERO && fz1 <= 0.0)
            ok = 1'b0;
    end

endmodule

// File: rtl/pwl_filter_reset_sequencer.sv
// Reset/config sequencer for the PWL linear filter.
// FP_RST_SWEEP_EN: halve the reset-path pole each reset cycle, floored at 2*fp1.
module pwl_filter_reset_sequencer
    import pwl_filter_seq_pkg::*;
#(
    parameter int  FILTER     = 0,
    parameter int  RST_CYC    = 8,
    parameter int  SETTLE_CYC = 16,
    parameter real FP_RST     = 1.0e9,
    parameter real FP_DEF     = 1.0e6,
    parameter int  CW         = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic cfg_req,
    input  real  cfg_fp1,
    input  real  cfg_fp2,
    input  real  cfg_fz1,
    input  logic cfg_en_complex,
    output logic cfg_ack,
    output logic cfg_err,
    output logic flt_reset,
    output real  flt_fp1,
    output real  flt_fp2,
    output real  flt_fz1,
    output real  flt_fp_rst,
    output logic flt_en_complex,
    output logic busy,
    output logic ready
);

    localparam int RST_N = (RST_CYC < 1) ? 1 : RST_CYC;
    localparam logic [CW-1:0] RST_LOAD = CW'(RST_N - 1);
    localparam logic [CW-1:0] SET_LOAD =
        (SETTLE_CYC < 1) ? '0 : CW'(SETTLE_CYC - 1);

    seq_state_t    state;
    logic [CW-1:0] cnt;
    logic          from_req;
    logic          ok;

    pwl_filter_seq_cfg_check #(
        .FILTER(FILTER)
    ) u_check (
        .fp1(cfg_fp1),
        .fp2(cfg_fp2),
        .fz1(cfg_fz1),
        .ok (ok)
    );

`ifdef FP_RST_SWEEP_EN
    real fp_half;
    real fp_floor;

    always_comb begin
        fp_half  = flt_fp_rst / 2.0;
        fp_floor = 2.0 * flt_fp1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_RESET;
            cnt            <= RST_LOAD;
            from_req       <= 1'b0;
            flt_reset      <= 1'b1;
            flt_fp1        <= FP_DEF;
            flt_fp2        <= FP_DEF;
            flt_fz1        <= FP_DEF;
            flt_fp_rst     <= FP_RST;
            flt_en_complex <= 1'b0;
            busy           <= 1'b1;
            ready          <= 1'b0;
            cfg_ack        <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                S_RESET: begin
`ifdef FP_RST_SWEEP_EN
                    flt_fp_rst <= (fp_half < fp_floor) ? fp_floor : fp_half;
`endif
                    if (cnt == '0) begin
                        flt_reset <= 1'b0;
                        if (SETTLE_CYC == 0) begin
                            state    <= S_IDLE;
                            ready    <= 1'b1;
                            busy     <= 1'b0;
                            cfg_ack  <= from_req;
                            from_req <= 1'b0;
                        end else begin
                            state <= S_SETTLE;
                            cnt   <= SET_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state    <= S_IDLE;
                        ready    <= 1'b1;
                        busy     <= 1'b0;
                        cfg_ack  <= from_req;
                        from_req <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    // the cycle right after an ack never samples the level request
                    if (cfg_req && !cfg_ack) begin
                        if (ok) begin
                            flt_fp1        <= cfg_fp1;
                            flt_fp2        <= cfg_fp2;
                            flt_fz1        <= cfg_fz1;
                            flt_en_complex <= cfg_en_complex;
                            flt_fp_rst     <= FP_RST;
                            flt_reset      <= 1'b1;
                            ready          <= 1'b0;
                            busy           <= 1'b1;
                            from_req       <= 1'b1;
                            state          <= S_RESET;
                            cnt            <= RST_LOAD;
                        end else begin
                            cfg_ack <= 1'b1;
                            cfg_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= S_RESET;
                    cnt       <= RST_LOAD;
                    flt_reset <= 1'b1;
                    busy      <= 1'b1;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwl_filter_reset_sequencer.sv
// Scoreboard bench for the PWL filter reset sequencer.
module tb_pwl_filter_reset_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic req0 = 1'b0, cplx0 = 1'b0;
    real  fp1_0 = 0.0, fp2_0 = 0.0, fz1_0 = 0.0;
    logic ack0, err0, frst0, fcplx0, busy0, rdy0;
    real  ffp1_0, ffp2_0, ffz1_0, ffprst0;

    logic req1 = 1'b0, cplx1 = 1'b0;
    real  fp1_1 = 0.0, fp2_1 = 0.0, fz1_1 = 0.0;
    logic ack1, err1, frst1, fcplx1, busy1, rdy1;
    real  ffp1_1, ffp2_1, ffz1_1, ffprst1;

    int errors = 0;
    int checks = 0;
    bit q0[$];
    bit q1[$];
    bit e0, e1;

    always #5 clk = ~clk;

    pwl_filter_reset_sequencer #(
        .FILTER(2)
    ) u0 (
        .clk(clk), .reset(reset),
        .cfg_req(req0), .cfg_fp1(fp1_0), .cfg_fp2(fp2_0),
        .cfg_fz1(fz1_0), .cfg_en_complex(cplx0),
        .cfg_ack(ack0), .cfg_err(err0), .flt_reset(frst0),
        .flt_fp1(ffp1_0), .flt_fp2(ffp2_0), .flt_fz1(ffz1_0),
        .flt_fp_rst(ffprst0), .flt_en_complex(fcplx0),
        .busy(busy0), .ready(rdy0)
    );

    pwl_filter_reset_sequencer #(
        .FILTER(0), .RST_CYC(0), .SETTLE_CYC(0)
    ) u1 (
        .clk(clk), .reset(reset),
        .cfg_req(req1), .cfg_fp1(fp1_1), .cfg_fp2(fp2_1),
        .cfg_fz1(fz1_1), .cfg_en_complex(cplx1),
        .cfg_ack(ack1), .cfg_err(err1), .flt_reset(frst1),
        .flt_fp1(ffp1_1), .flt_fp2(ffp2_1), .flt_fz1(ffz1_1),
        .flt_fp_rst(ffprst1), .flt_en_complex(fcplx1),
        .busy(busy1), .ready(rdy1)
    );

    task automatic chk_b(input string n, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", n, got, exp);
        end
    endtask

    task automatic chk_r(input string n, input real got, input real exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%g exp=%g", n, got, exp);
        end
    endtask

    task automatic chk_i(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", n, got, exp);
        end
    endtask

    // ack monitor: every ack must match a queued expectation
    always @(negedge clk) begin
        if (ack0 === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL ack0_unexpected got=ack exp=none");
            end else begin
                e0 = q0.pop_front();
                if (err0 !== e0) begin
                    errors++;
                    $display("FAIL ack0_err got=%b exp=%b", err0, e0);
                end
            end
        end
        if (ack1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL ack1_unexpected got=ack exp=none");
            end else begin
                e1 = q1.pop_front();
                if (err1 !== e1) begin
                    errors++;
                    $display("FAIL ack1_err got=%b exp=%b", err1, e1);
                end
            end
        end
    end

    initial begin
        int first_lo;
        int first_rdy;
        int n;

        // 1: system reset and default sequence
        repeat (3) @(negedge clk);
        chk_b("rst_flt_reset", frst0, 1'b1);
        chk_b("rst_busy", busy0, 1'b1);
        chk_b("rst_ready", rdy0, 1'b0);
        chk_b("rst_ack", ack0, 1'b0);
        chk_r("rst_fp1", ffp1_0, 1.0e6);
        chk_r("rst_fp_rst", ffprst0, 1.0e9);
        chk_b("rst_cplx", fcplx0, 1'b0);
        reset = 1'b0;
        first_lo = 0;
        first_rdy = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (!frst0 && first_lo == 0) first_lo = k;
            if (rdy0 && first_rdy == 0) first_rdy = k;
        end
        chk_i("t1_reset_release_edge", first_lo, 8);
        chk_i("t1_ready_edge", first_rdy, 24);
        chk_r("t1_fp1_default", ffp1_0, 1.0e6);
        chk_b("t1_busy_low", busy0, 1'b0);

        // 2: valid config
        fp1_0 = 2.0e6; fp2_0 = 5.0e6; fz1_0 = 1.0e5;
        cplx0 = 1'b1; req0 = 1'b1;
        q0.push_back(1'b0);
        @(negedge clk);
        chk_b("t2_flt_reset", frst0, 1'b1);
        chk_r("t2_fp1_in_reset", ffp1_0, 2.0e6);
        chk_r("t2_fp2_in_reset", ffp2_0, 5.0e6);
        chk_r("t2_fz1_in_reset", ffz1_0, 1.0e5);
        chk_b("t2_cplx", fcplx0, 1'b1);
        chk_r("t2_fp_rst", ffprst0, 1.0e9);
        chk_b("t2_ready_low", rdy0, 1'b0);
        chk_b("t2_busy", busy0, 1'b1);
        n = 1;
        while (!ack0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk_i("t2_latency", n, 25);
        chk_b("t2_ready", rdy0, 1'b1);
        chk_b("t2_busy_done", busy0, 1'b0);
        chk_b("t2_flt_reset_low", frst0, 1'b0);
        req0 = 1'b0;
        @(negedge clk);

        // 3: invalid config, single ack for a held level request
        fp1_0 = 0.0;
        req0 = 1'b1;
        q0.push_back(1'b1);
        @(negedge clk);
        chk_b("t3_ack", ack0, 1'b1);
        chk_b("t3_err", err0, 1'b1);
        chk_b("t3_ready", rdy0, 1'b1);
        chk_r("t3_fp1_kept", ffp1_0, 2.0e6);
        chk_b("t3_flt_reset", frst0, 1'b0);
        @(negedge clk);
        chk_b("t3_no_double_ack", ack0, 1'b0);
        req0 = 1'b0;
        @(negedge clk);

        // 4: reset during settle drops the request
        fp1_0 = 3.0e6; fp2_0 = 4.0e6; fz1_0 = 2.0e5;
        req0 = 1'b1;
        repeat (12) @(negedge clk);
        chk_b("t4_in_settle", frst0, 1'b0);
        chk_b("t4_busy", busy0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk_r("t4_fp1_default", ffp1_0, 1.0e6);
        chk_b("t4_flt_reset", frst0, 1'b1);
        chk_b("t4_busy_rst", busy0, 1'b1);
        chk_b("t4_ready", rdy0, 1'b0);
        reset = 1'b0;
        req0 = 1'b0;
        repeat (30) @(negedge clk);
        chk_b("t4_ready_after", rdy0, 1'b1);
        chk_r("t4_fp1_after", ffp1_0, 1.0e6);

        // 5: zero reset/settle lengths, one-pole filter ignores fp2
        fp1_1 = 5.0e5; fp2_1 = 0.0;
        req1 = 1'b1;
        q1.push_back(1'b0);
        @(negedge clk);
        chk_b("t5_flt_reset", frst1, 1'b1);
        chk_b("t5_ack_early", ack1, 1'b0);
        @(negedge clk);
        chk_b("t5_ack_2cyc", ack1, 1'b1);
        chk_b("t5_reset_1cyc", frst1, 1'b0);
        chk_b("t5_ready", rdy1, 1'b1);
        chk_r("t5_fp1", ffp1_1, 5.0e5);
        req1 = 1'b0;
        @(negedge clk);
        chk_b("t5_reset_stays_low", frst1, 1'b0);
        fp1_1 = -1.0;
        req1 = 1'b1;
        q1.push_back(1'b1);
        @(negedge clk);
        chk_b("t5_neg_ack", ack1, 1'b1);
        req1 = 1'b0;
        @(negedge clk);

`ifdef FP_RST_SWEEP_EN
        // 6: reset-path pole sweep
        begin
            real sw[5];
            sw = '{1.0e9, 5.0e8, 2.5e8, 2.0e8, 2.0e8};
            fp1_0 = 1.0e8; fp2_0 = 1.0e8; fz1_0 = 1.0e8;
            req0 = 1'b1;
            q0.push_back(1'b0);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk_r("t6_fp_rst_sweep", ffprst0, sw[k]);
            end
            n = 5;
            while (!ack0 && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk_i("t6_latency", n, 25);
            req0 = 1'b0;
            @(negedge clk);
        end
`endif

        repeat (3) @(negedge clk);
        chk_i("q0_drained", q0.size(), 0);
        chk_i("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
